// File: rtl/watch_pkg.sv
// Shared encodings for the watch time-setting controller: FSM states,
// field-select codes and the default inactivity timeout.
package watch_pkg;

   typedef enum logic [2:0] {
      S_RUN      = 3'd0,
      S_SET_HOUR = 3'd1,
      S_SET_MIN  = 3'd2,
      S_SET_SEC  = 3'd3,
      S_ALM_HOUR = 3'd4,
      S_ALM_MIN  = 3'd5
   } state_e;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_HOUR = 2'd1;
   localparam logic [1:0] SEL_MIN  = 2'd2;
   localparam logic [1:0] SEL_SEC  = 2'd3;

   localparam int TIMEOUT_SEC_DEF = 30;

   // Unused or illegal encodings map to SEL_NONE, which also marks "not editing".
   function automatic logic [1:0] sel_of(input state_e s);
      case (s)
         S_SET_HOUR, S_ALM_HOUR: sel_of = SEL_HOUR;
         S_SET_MIN,  S_ALM_MIN:  sel_of = SEL_MIN;
         S_SET_SEC:              sel_of = SEL_SEC;
         default:                sel_of = SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/watch_timeout_cnt.sv
// Inactivity counter: counts tick_1hz while enabled and pulses expire on the
// tick that would reach TIMEOUT_SEC; clear or disable holds it at zero.
module watch_timeout_cnt
   import watch_pkg::*;
#(
   parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF,
   parameter int TO_W        = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   input  logic enable,
   output logic expire
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_SEC - 1);

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      expire = enable & tick & ~clear & (cnt_q == LAST);
      cnt_d  = cnt_q;
      if (!enable || clear) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = expire ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/watch_set_controller.sv
// Time-setting UI sequencer for the watch. Optional alarm-setting states are
// built when WATCH_ALARM_SET_EN is defined.
//
// state      | meaning
// S_RUN      | normal timekeeping, buttons other than mode ignored
// S_SET_HOUR | editing time hours, counters frozen
// S_SET_MIN  | editing time minutes, counters frozen
// S_SET_SEC  | editing seconds (inc clears), counters frozen
// S_ALM_HOUR | editing alarm hours, time keeps running
// S_ALM_MIN  | editing alarm minutes, time keeps running
module watch_set_controller
   import watch_pkg::*;
#(
   parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF,
   parameter int TO_W        = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       mode_pulse,
   input  logic       next_pulse,
   input  logic       inc_pulse,
   output logic       run_en,
   output logic       inc_hour,
   output logic       inc_min,
   output logic       clr_sec,
   output logic [1:0] sel,
   output logic       blink,
   output logic       alarm_sel
);

`ifdef WATCH_ALARM_SET_EN
   localparam state_e SET_EXIT = S_ALM_HOUR;
`else
   localparam state_e SET_EXIT = S_RUN;
`endif

   state_e     state_q, state_d;
   logic       run_en_q, run_en_d;
   logic       inc_hour_q, inc_hour_d;
   logic       inc_min_q, inc_min_d;
   logic       clr_sec_q, clr_sec_d;
   logic [1:0] sel_q, sel_d;
   logic       blink_q, blink_d;
   logic       alarm_sel_q, alarm_sel_d;
   logic       inc_acc;
   logic       editing;
   logic       expire;

   assign editing = (sel_of(state_q) != SEL_NONE);

   watch_timeout_cnt #(
      .TIMEOUT_SEC (TIMEOUT_SEC),
      .TO_W        (TO_W)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (mode_pulse | next_pulse | inc_pulse),
      .tick   (tick_1hz),
      .enable (editing),
      .expire (expire)
   );

   always_comb begin
      state_d    = state_q;
      inc_hour_d = 1'b0;
      inc_min_d  = 1'b0;
      clr_sec_d  = 1'b0;
      inc_acc    = 1'b0;
      case (state_q)
         S_RUN: begin
            if (mode_pulse) state_d = S_SET_HOUR;
         end
         S_SET_HOUR: begin
            if (mode_pulse)      state_d = SET_EXIT;
            else if (next_pulse) state_d = S_SET_MIN;
            else if (inc_pulse)  begin inc_hour_d = 1'b1; inc_acc = 1'b1; end
            else if (expire)     state_d = S_RUN;
         end
         S_SET_MIN: begin
            if (mode_pulse)      state_d = SET_EXIT;
            else if (next_pulse) state_d = S_SET_SEC;
            else if (inc_pulse)  begin inc_min_d = 1'b1; inc_acc = 1'b1; end
            else if (expire)     state_d = S_RUN;
         end
         S_SET_SEC: begin
            if (mode_pulse)      state_d = SET_EXIT;
            else if (next_pulse) state_d = S_SET_HOUR;
            else if (inc_pulse)  begin clr_sec_d = 1'b1; inc_acc = 1'b1; end
            else if (expire)     state_d = S_RUN;
         end
`ifdef WATCH_ALARM_SET_EN
         S_ALM_HOUR: begin
            if (mode_pulse)      state_d = S_RUN;
            else if (next_pulse) state_d = S_ALM_MIN;
            else if (inc_pulse)  begin inc_hour_d = 1'b1; inc_acc = 1'b1; end
            else if (expire)     state_d = S_RUN;
         end
         S_ALM_MIN: begin
            if (mode_pulse)      state_d = S_RUN;
            else if (next_pulse) state_d = S_ALM_HOUR;
            else if (inc_pulse)  begin inc_min_d = 1'b1; inc_acc = 1'b1; end
            else if (expire)     state_d = S_RUN;
         end
`endif
         default: state_d = S_RUN;
      endcase

      run_en_d = !(state_d == S_SET_HOUR || state_d == S_SET_MIN || state_d == S_SET_SEC);
      sel_d    = sel_of(state_d);
`ifdef WATCH_ALARM_SET_EN
      alarm_sel_d = (state_d == S_ALM_HOUR || state_d == S_ALM_MIN);
`else
      alarm_sel_d = 1'b0;
`endif

      // Entry or adjustment keeps the field lit; toggling only happens when idle.
      if (sel_d == SEL_NONE)                   blink_d = 1'b0;
      else if (state_d != state_q || inc_acc)  blink_d = 1'b1;
      else if (tick_1hz)                       blink_d = ~blink_q;
      else                                     blink_d = blink_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_RUN;
         run_en_q    <= 1'b1;
         inc_hour_q  <= 1'b0;
         inc_min_q   <= 1'b0;
         clr_sec_q   <= 1'b0;
         sel_q       <= SEL_NONE;
         blink_q     <= 1'b0;
         alarm_sel_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_en_q    <= run_en_d;
         inc_hour_q  <= inc_hour_d;
         inc_min_q   <= inc_min_d;
         clr_sec_q   <= clr_sec_d;
         sel_q       <= sel_d;
         blink_q     <= blink_d;
         alarm_sel_q <= alarm_sel_d;
      end
   end

   assign run_en    = run_en_q;
   assign inc_hour  = inc_hour_q;
   assign inc_min   = inc_min_q;
   assign clr_sec   = clr_sec_q;
   assign sel       = sel_q;
   assign blink     = blink_q;
   assign alarm_sel = alarm_sel_q;

endmodule
